// File: rtl/nf10_axis_header_insert.sv
// ---------------------------------------------------------------------------
// nf10_axis_header_insert
//
// AXI4-Stream header inserter. For each packet it prepends C_HDR_WORDS
// 64-bit header words taken from hdr_data (word 0 first), then forwards the
// payload unchanged. insert_en, sampled at packet start, selects between
// header insertion and plain pass-through. The output is a single register
// stage that sustains one word per cycle during the payload.
//
// Optional build macro: NF10_HDR_SEQNUM_EN
//   When defined, a 32-bit sequence number replaces bits [31:0] of the last
//   header word at latch time. It increments once per inserted header and is
//   not advanced by pass-through packets.
//
// Ports:
//   aclk, aresetn      clock, synchronous active-low reset
//   s_axis_*           payload input stream (tvalid/tready/tdata/tstrb/tlast)
//   m_axis_*           output stream (tvalid/tready/tdata/tstrb/tlast)
//   insert_en          1 = prepend header to the next packet, 0 = pass through
//   hdr_data           header contents, word k = hdr_data[64k+63:64k]
//   pkt_count          number of packets whose tlast has been forwarded
// ---------------------------------------------------------------------------
module nf10_axis_header_insert #(
  parameter int C_M_AXIS_DATA_WIDTH = 64,
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_HDR_WORDS         = 2
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                             s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                             m_axis_tlast,
  input  logic                             insert_en,
  input  logic [64*C_HDR_WORDS-1:0]        hdr_data,
  output logic [31:0]                      pkt_count
);

  localparam int IDX_W = (C_HDR_WORDS > 1) ? $clog2(C_HDR_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_HDR_WORDS - 1);
  localparam logic [C_M_AXIS_DATA_WIDTH/8-1:0] STRB_ALL = {(C_M_AXIS_DATA_WIDTH/8){1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t                                   state_q, state_d;
  logic [IDX_W-1:0]                         hdr_cnt_q, hdr_cnt_d;
  logic [C_HDR_WORDS-1:0][63:0]             hdr_reg_q, hdr_reg_d;
  logic [C_HDR_WORDS-1:0][63:0]             hdr_latch_s;
  logic [31:0]                              pkt_count_q, pkt_count_d;
  logic                                     m_tvalid_q;
  logic [C_M_AXIS_DATA_WIDTH-1:0]           m_tdata_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]         m_tstrb_q;
  logic                                     m_tlast_q;
  logic                                     adv_s;
  logic                                     s_ready_s;
  logic                                     emit_s;
  logic [C_M_AXIS_DATA_WIDTH-1:0]           emit_data_s;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]         emit_strb_s;
  logic                                     emit_last_s;
`ifdef NF10_HDR_SEQNUM_EN
  logic [31:0]                              seq_q, seq_d;
`endif

  // The output register can take a new word when empty or being drained.
  assign adv_s         = !m_tvalid_q || m_axis_tready;
  assign s_ready_s     = (state_q == ST_PAYLOAD) && adv_s;
  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tlast  = m_tlast_q;
  assign pkt_count     = pkt_count_q;

  // Header image as it will be latched, with the optional sequence overlay.
  always_comb begin
    hdr_latch_s = hdr_data;
`ifdef NF10_HDR_SEQNUM_EN
    hdr_latch_s[C_HDR_WORDS-1][31:0] = seq_q;
`endif
  end

  // Next-state logic and selection of the word offered to the output register.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    hdr_reg_d   = hdr_reg_q;
    pkt_count_d = pkt_count_q;
    emit_s      = 1'b0;
    emit_data_s = '0;
    emit_strb_s = '0;
    emit_last_s = 1'b0;
`ifdef NF10_HDR_SEQNUM_EN
    seq_d       = seq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The source word is only looked at here, never consumed.
        if (s_axis_tvalid && adv_s) begin
          if (insert_en) begin
            hdr_reg_d   = hdr_latch_s;
            emit_s      = 1'b1;
            emit_data_s = hdr_latch_s[0];
            emit_strb_s = STRB_ALL;
`ifdef NF10_HDR_SEQNUM_EN
            seq_d       = seq_q + 32'd1;
`endif
            if (C_HDR_WORDS == 1) begin
              state_d   = ST_PAYLOAD;
              hdr_cnt_d = '0;
            end else begin
              state_d   = ST_HDR;
              hdr_cnt_d = IDX_W'(1'b1);
            end
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (adv_s) begin
          emit_s      = 1'b1;
          emit_data_s = hdr_reg_q[hdr_cnt_q];
          emit_strb_s = STRB_ALL;
          if (hdr_cnt_q == LAST_IDX) begin
            state_d   = ST_PAYLOAD;
            hdr_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (s_axis_tvalid && s_ready_s) begin
          emit_s      = 1'b1;
          emit_data_s = s_axis_tdata;
          emit_strb_s = s_axis_tstrb;
          emit_last_s = s_axis_tlast;
          if (s_axis_tlast) begin
            pkt_count_d = pkt_count_q + 32'd1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        hdr_cnt_d = '0;
      end
    endcase
  end

  // State registers and the output stage, with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      hdr_cnt_q   <= '0;
      hdr_reg_q   <= '0;
      pkt_count_q <= 32'd0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tstrb_q   <= '0;
      m_tlast_q   <= 1'b0;
`ifdef NF10_HDR_SEQNUM_EN
      seq_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_reg_q   <= hdr_reg_d;
      pkt_count_q <= pkt_count_d;
`ifdef NF10_HDR_SEQNUM_EN
      seq_q       <= seq_d;
`endif
      // Data/strb/last only move when a word is loaded, so they stay stable
      // during backpressure.
      if (adv_s) begin
        if (emit_s) begin
          m_tvalid_q <= 1'b1;
          m_tdata_q  <= emit_data_s;
          m_tstrb_q  <= emit_strb_s;
          m_tlast_q  <= emit_last_s;
        end else begin
          m_tvalid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/nf10_axis_header_insert.md
Name: nf10_axis_header_insert

Overview:
- AXI4-Stream packet header inserter: prepends C_HDR_WORDS 64-bit header words to each packet, then forwards the payload unchanged.
- Transmit-side counterpart of the header-removal stage.
- Sits between the packet source (e.g. DMA or host path) and the output port path.
- Registered output stage; sustains 1 word/cycle in the payload phase.

Parameters:
- C_M_AXIS_DATA_WIDTH, 64, master data width (only 64 supported).
- C_S_AXIS_DATA_WIDTH, 64, slave data width (only 64 supported).
- C_HDR_WORDS, 2, header length in 64-bit words (legal range 1..8).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_axis_tvalid  in  1  payload word valid.
- s_axis_tready  out  1  payload word accepted.
- s_axis_tdata  in  64  payload data.
- s_axis_tstrb  in  8  payload byte strobes.
- s_axis_tlast  in  1  last payload word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  64  output data.
- m_axis_tstrb  out  8  output byte strobes.
- m_axis_tlast  out  1  last output word.
- insert_en  in  1  per-packet enable, sampled at packet start; 0 = pass through with no header.
- hdr_data  in  64*C_HDR_WORDS  header contents; word k = hdr_data[64k+63:64k]; word 0 is sent first.
- pkt_count  out  32  packets completed (tlast forwarded); wraps at 2^32.

Behaviour:
- Reset: aresetn is synchronous, active-low; clock is aclk. All state is cleared on any aclk edge with aresetn=0, including mid-packet; any partial packet is dropped (no tlast emitted). Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tstrb=0, m_axis_tlast=0, s_axis_tready=0, pkt_count=0, FSM=IDLE, hdr_cnt=0.
- Output register: define adv = !m_axis_tvalid || m_axis_tready. When adv=1 and a word is produced, load the m_axis_* registers and set tvalid=1. When adv=1 and no word is produced, clear tvalid. While m_axis_tvalid=1 and m_axis_tready=0, data, strb and last hold stable.
- s_axis_tready is combinational: (state==PAYLOAD) && adv. It is 0 in IDLE and HDR.
- FSM state IDLE, on s_axis_tvalid=1 and adv=1:
  - Sample insert_en.
  - If insert_en=1: latch hdr_data into hdr_reg, emit header word 0 (strb=0xFF, last=0), set hdr_cnt=1, go to HDR (or to PAYLOAD if C_HDR_WORDS=1).
  - If insert_en=0: go to PAYLOAD, emit nothing (1-cycle bubble).
  - The s_axis word is not consumed in IDLE.
- FSM state HDR, on adv=1:
  - Emit hdr_reg word hdr_cnt (strb=0xFF, last=0), then hdr_cnt++.
  - After emitting word C_HDR_WORDS-1, go to PAYLOAD.
  - Changes to hdr_data after the latch have no effect on the current packet.
- FSM state PAYLOAD, on s_axis_tvalid && s_axis_tready:
  - Emit s_axis_tdata, s_axis_tstrb and s_axis_tlast unchanged.
  - If tlast=1: pkt_count++ and go to IDLE.
- Latency: first output word appears 1 cycle after s_axis_tvalid is seen in IDLE. Payload latency is 1 cycle.
- Packet gap: 1 idle cycle per packet (the IDLE state).
- Single-word packets (tlast on the first word) are legal and are handled normally.
- A tvalid=0 gap mid-payload produces output bubbles only; the FSM state is unchanged.
- Output word count per packet is exactly C_HDR_WORDS + payload words (insert_en=1) or payload words (insert_en=0).

Optional Feature:
- Macro: NF10_HDR_SEQNUM_EN.
- Defined:
  - A 32-bit seq counter (reset 0) is kept.
  - For each packet with insert_en=1, bits [31:0] of header word C_HDR_WORDS-1 are replaced at latch time with the current seq value.
  - seq then increments and wraps 0xFFFFFFFF→0.
  - Pass-through packets (insert_en=0) do not increment seq.
- Not defined: the header is sent verbatim from hdr_data and no counter logic is present.

Test Plan:
- C_HDR_WORDS=2, hdr_data={64'hBBBB..., 64'hAAAA...}, insert_en=1, 3-word payload P0..P2 (P2 tlast, strb 0x0F), m_axis_tready=1 → output AAAA, BBBB, P0, P1, P2. Only P2 has tlast with strb 0x0F; header strbs are 0xFF; pkt_count=1.
- Same packet with m_axis_tready toggling 1010... → identical word sequence; data is stable while tvalid=1 && tready=0; no words lost or duplicated.
- insert_en=0, 2-word payload → output is exactly the 2 payload words; pkt_count increments.
- Back-to-back packets, second with a 1-word payload (tlast on first word) → second output is the 2 header words + 1 word; 1 idle cycle between packets; pkt_count=2.
- aresetn=0 for 1 cycle while in HDR after header word 0 → m_axis_tvalid=0 next cycle, pkt_count=0. The next packet starts cleanly with header word 0.
- NF10_HDR_SEQNUM_EN defined, 3 packets with insert_en=1,0,1 → header word 1 low 32 bits are 0 on the first packet and 1 on the third.
